// File: rtl/mac_pkg.sv
// Shared definitions for the floating-point MAC sequencer and its helpers.
// Combinational-only content: state encoding, default latencies, stage widths.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RD_LAT_DEF   = 1;
  localparam int PIPE_LAT_DEF = 4;
  localparam int EXP_W        = 8;
  localparam int SIG_W        = 22;
  // Wide enough for the largest RD_LAT + PIPE_LAT (4 + 8).
  localparam int DRAIN_W      = 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } stage_t;

endpackage

// File: rtl/mac_drain_cnt.sv
// Loadable down-counter with enable and a ==1 flag; load wins over enable.
// One-cycle update latency; holds its value whenever en is low.
module mac_drain_cnt #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         is_one
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign is_one = (cnt == W'(1));

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: issues len operand reads, drains RD_LAT+PIPE_LAT stages, holds result.
// Result valid N+RD_LAT+PIPE_LAT+1 cycles after start; stall freezes ISSUE/DRAIN one cycle each.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] base_addr,
  input  logic             stall,
  input  logic             abort,
  output logic             rd_en,
  output logic [LEN_W-1:0] rd_addr,
  output logic             pipe_en,
  output logic             first_tag,
  output logic             acc_clr,
  output logic             busy,
  output logic             result_valid,
  output logic             result_zero,
  input  logic             result_ready
);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   base_q, len_q, count_q;
  logic               acc_clr_q, result_zero_q;
  logic               issue, accept_job, drain_load, drain_en, drain_one;
  logic [DRAIN_W-1:0] drain_cnt;

  mac_drain_cnt #(.W(DRAIN_W)) u_drain_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .load     (drain_load),
    .load_val (DRAIN_W'(RD_LAT + PIPE_LAT)),
    .en       (drain_en),
    .cnt      (drain_cnt),
    .is_one   (drain_one)
  );

  assign accept_job = (state == IDLE) && start && !abort && (len != '0);

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    drain_load = 1'b0;
    drain_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = (len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!stall) begin
          issue = 1'b1;
          if (count_q == len_q - LEN_W'(1)) begin
            drain_load = 1'b1;
            state_nxt  = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!stall) begin
          drain_en = 1'b1;
          if (drain_one) state_nxt = DONE;
        end
      end
      DONE: begin
        if (abort || result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      count_q       <= '0;
      acc_clr_q     <= 1'b0;
      result_zero_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc_clr_q <= accept_job || ((state != IDLE) && abort);
      if (accept_job) begin
        base_q  <= base_addr;
        len_q   <= len;
        count_q <= '0;
      end else if (issue) begin
        count_q <= count_q + LEN_W'(1);
      end
      // Only a zero-length start reaches DONE with result_zero; it then holds until leaving DONE.
      if (state == IDLE) result_zero_q <= start && !abort && (len == '0);
      else if (state_nxt != DONE) result_zero_q <= 1'b0;
    end
  end

  assign rd_en        = issue;
  assign rd_addr      = base_q + count_q;
  assign first_tag    = issue && (count_q == '0);
  assign pipe_en      = ((state == ISSUE) || (state == DRAIN)) && !stall && !abort;
  assign acc_clr      = acc_clr_q;
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign result_zero  = result_zero_q;

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for the pipelined floating-point MAC datapath (sign / 8-bit exponent / 22-bit significand-product stage registers). It runs one dot product of length len: issues operand-buffer reads, drives the pipeline enable and accumulator-clear tag, and tracks in-flight operands through a stall-aware drain. It then holds a result-valid handshake until the consumer accepts. It sits between the host/command interface and the MAC stage registers.

Parameters:
LEN_W, 8, width of length and read-address counters
RD_LAT, 1, cycles from rd_en to operand pair at MAC input (1..4)
PIPE_LAT, 4, MAC stages from operand input to accumulator write (1..8)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
len  in  LEN_W  number of operand pairs; sampled with start
base_addr  in  LEN_W  first operand-buffer address; sampled with start
stall  in  1  downstream back-pressure; freezes the sequence
abort  in  1  synchronous cancel of the current job
rd_en  out  1  operand-buffer read strobe
rd_addr  out  LEN_W  operand-buffer read address
pipe_en  out  1  enable for all MAC stage registers
first_tag  out  1  high with the read of element 0; MAC delays it RD_LAT+PIPE_LAT and uses it to load rather than add
acc_clr  out  1  one-cycle accumulator clear pulse
busy  out  1  high in every state except IDLE
result_valid  out  1  accumulator holds the final result
result_zero  out  1  qualifies result_valid: job had len==0, consumer treats result as +0
result_ready  in  1  consumer accepts the result

Behaviour:
- Reset (async, resetn low): state IDLE; all outputs 0; counters 0. Reset mid-job discards the job. No result is produced.
- States: IDLE, ISSUE, DRAIN, DONE. Registered Moore outputs, except rd_en and pipe_en, which are gated combinationally by !stall.
- IDLE: start=1 and len!=0 latches base_addr and len, clears the issue count, pulses acc_clr for one cycle, then moves to ISSUE. start=1 and len==0 moves directly to DONE with result_zero=1.
- ISSUE: each cycle with stall=0:
  - rd_en=1, rd_addr=base_addr+count (mod 2^LEN_W, so wrap-around is legal), count++.
  - first_tag=1 only when count==0.
  - On the issue with count==len-1, load drain_cnt=RD_LAT+PIPE_LAT and move to DRAIN.
  - With stall=1: rd_en=0, first_tag=0, count held.
- pipe_en = busy & !stall & (state!=DONE). While stalled, the pipeline and all counters hold.
- DRAIN: each unstalled cycle, drain_cnt--. When drain_cnt==1 and stall=0, move to DONE.
- DONE: result_valid=1; result_zero is held. When result_ready=1, move to IDLE and drop result_valid/result_zero the next cycle. stall is ignored in DONE.
- Latency, no stall, len=N≥1, start accepted at cycle 0:
  - rd_en high cycles 1..N.
  - result_valid first high at cycle N+RD_LAT+PIPE_LAT+1.
  - Each stalled cycle during ISSUE or DRAIN adds exactly one cycle.
- start is ignored outside IDLE. start and abort together in IDLE: abort wins, no job starts.
- abort=1 in ISSUE, DRAIN or DONE:
  - Next cycle: IDLE, acc_clr pulse, result_valid=0.
  - rd_en and pipe_en are 0 in the abort cycle itself.
- len=1: a single issue cycle (first_tag=1), then DRAIN.
- len=2^LEN_W-1 is the maximum job length.

Decomposition:
- Shared package mac_pkg: state encoding constants (IDLE=0, ISSUE=1, DRAIN=2, DONE=3), default RD_LAT/PIPE_LAT, and exponent/significand widths (8/22) for the stage registers.
- One sub-module is natural: mac_drain_cnt, a loadable down-counter with enable and a ==1 flag, reusable by other pipeline controllers.
- The rest is one FSM module.

Test Plan:
- len=3, base=0x10, no stall -> rd_en cycles 1-3, rd_addr 0x10/0x11/0x12, first_tag only at cycle 1, acc_clr at cycle 1, result_valid at cycle 9.
- len=3, stall high on cycles 2 and 7 -> rd_addr sequence unchanged, pipe_en low on both cycles, result_valid at cycle 11.
- len=0 -> DONE next cycle with result_valid=1 and result_zero=1, rd_en never asserted.
- base=0xFE, len=4 -> rd_addr 0xFE, 0xFF, 0x00, 0x01.
- abort asserted at cycle 2 of a len=5 job -> IDLE at cycle 3, acc_clr pulse, no result_valid; a new start with len=1 then completes in 1+5+1 cycles.
- result_ready held low 10 cycles in DONE -> result_valid stays high and start is ignored; resetn pulsed low mid-DRAIN -> all outputs 0 immediately, then IDLE.
